mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
// - MEM/WB pipeline register plus write-back select; sits directly upstream of the register file and drives its single write port.
// - Captures the MEM-stage results and the destination register, selects the write-back value, and presents a registered write request one cycle later.
// - Provides WB-to-ID bypass for both read operands, a sticky bad-address flag and a saturating retired-write counter.
// PARAMETERS
// - N      32  datapath width
// - DEPTH  16  number of architectural registers; addresses >= DEPTH are invalid
// - CNT_W  32  width of the retired-write counter
// PORTS
// - clk           in   1    single clock; all state updates on posedge
// - rst_n         in   1    asynchronous active-low reset
// - stall         in   1    hold all pipeline state; no capture, no retire
// - flush         in   1    kill the instruction being captured this cycle
// - mem_valid     in   1    MEM stage holds a valid instruction
// - mem_reg_write in   1    instruction writes a register
// - mem_reg_dst   in   1    1: destination = mem_rd, 0: destination = mem_rt
// - mem_rd        in   5    rd field
// - mem_rt        in   5    rt field
// - mem_to_reg    in   3    write-back source select code
// - mem_even_flag in   1    condition for code 3'b100 (addie)
// - mem_alu_res   in   N    ALU result
// - mem_load_data in   N    data memory read data
// - mem_link_data in   N    link/PC value
// - mem_imm_data  in   N    immediate/auxiliary result
// - id_rs         in   5    ID-stage rs, for bypass
// - id_rt         in   5    ID-stage rt, for bypass
// - wb_we         out  1    register-file write enable
// - wb_addr       out  5    register-file write address
// - wb_data       out  N    register-file write data
// - fwd_a_hit     out  1    wb write targets id_rs
// - fwd_b_hit     out  1    wb write targets id_rt
// - fwd_data      out  N    bypass value (equals wb_data)
// - addr_err      out  1    sticky: a write to an address >= DEPTH was suppressed
// - wr_count      out  CNT_W  number of retired writes, saturating
// BEHAVIOUR
// - Reset: wb_we=0, wb_addr=0, wb_data=0, addr_err=0, wr_count=0; fwd_* hits are therefore 0.
// - Destination: dst = mem_reg_dst ? mem_rd : mem_rt.
// - Select: 000 alu_res, 001 load_data, 010 link_data, 011 imm_data.
// - Code 100 selects imm_data only if mem_even_flag=1; otherwise the write is cancelled (we=0).
// - Codes 101/110/111 select alu_res.
// - Capture on posedge when !stall:
//   - we_next = mem_valid & mem_reg_write & !flush & cond_ok & (dst < DEPTH).
//   - wb_addr <= dst and wb_data <= selected value, updated even when we_next=0.
// - Latency: exactly 1 cycle from MEM inputs to wb_*.
// - The register file samples wb_* on the following edge.
// - stall=1: all registers hold, including wb_we; a held write is not re-counted.
// - Priority: stall over flush. flush with stall is ignored for that cycle.
// - Bad address: if mem_valid & mem_reg_write & !flush & cond_ok & dst >= DEPTH, on a non-stalled edge:
//   - wb_we <= 0
//   - addr_err <= 1, sticky until reset.
// - Counter: wr_count increments on each non-stalled edge where we_next=1; it saturates at all-ones with no wrap.
// - Bypass (combinational from registered state):
//   - fwd_a_hit = wb_we & (wb_addr == id_rs)
//   - fwd_b_hit = wb_we & (wb_addr == id_rt)
//   - fwd_data = wb_data
//   - Register 0 is not special-cased.
// - Reset mid-operation clears any in-flight write immediately (asynchronous); no partial write reaches the register file.
// STRUCTURE
// - Shared package: N default, DEPTH default, and MEM_TO_REG codes as localparams: M2R_ALU=3'b000, M2R_LOAD=3'b001, M2R_LINK=3'b010, M2R_IMM=3'b011, M2R_ADDIE=3'b100.
// - One sub-module, wb_select: purely combinational; produces data and cond_ok from mem_to_reg, mem_even_flag and the four data inputs.
// - Pipeline register, counter, error flag and bypass compare live in mem_wb_stage.
// TESTING
// - ALU write: valid=1, reg_write=1, reg_dst=1, rd=5, code 000, alu=0x1234.
//   - Next cycle: wb_we=1, wb_addr=5, wb_data=0x1234, wr_count=1.
// - addie: code 100, imm=0x7, rt=3, reg_dst=0.
//   - even=1: wb_we=1, addr=3, data=7.
//   - even=0: wb_we=0, count unchanged.
// - Stall/flush: capture a write, then stall=1 for 3 cycles with new inputs.
//   - wb_* hold, wr_count stays 1.
//   - flush=1 with stall=0: wb_we=0.
//   - flush=1 with stall=1: ignored.
// - Bad address: rd=20 with DEPTH=16.
//   - wb_we=0, addr_err=1, and it stays 1 after later valid writes until rst_n=0.
// - Bypass: wb_we=1, wb_addr=9, wb_data=0xBEEF.
//   - id_rs=9, id_rt=2: fwd_a_hit=1, fwd_b_hit=0, fwd_data=0xBEEF.
// - Reset and saturation: assert rst_n=0 mid-stream; all outputs go to 0 asynchronously.
//   - With CNT_W=4 and 20 writes: wr_count=15.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared defaults and write-back source codes for the MEM/WB stage
package mem_wb_stage_pkg;

    localparam int N_DEF     = 32;
    localparam int DEPTH_DEF = 16;
    localparam int CNT_W_DEF = 32;

    localparam logic [2:0] M2R_ALU   = 3'b000;
    localparam logic [2:0] M2R_LOAD  = 3'b001;
    localparam logic [2:0] M2R_LINK  = 3'b010;
    localparam logic [2:0] M2R_IMM   = 3'b011;
    localparam logic [2:0] M2R_ADDIE = 3'b100;

endpackage

// File: rtl/mem_wb_stage_wb_select.sv
// rtl/mem_wb_stage_wb_select.sv - combinational write-back value select
// Ports: mem_to_reg/mem_even_flag pick one of alu/load/link/imm onto data;
//        cond_ok=0 cancels the write (addie with an odd condition).
module wb_select
    import mem_wb_stage_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [2:0]   mem_to_reg,
    input  logic         mem_even_flag,
    input  logic [N-1:0] alu_res,
    input  logic [N-1:0] load_data,
    input  logic [N-1:0] link_data,
    input  logic [N-1:0] imm_data,
    output logic [N-1:0] data,
    output logic         cond_ok
);

    always_comb begin
        data    = alu_res;
        cond_ok = 1'b1;
        case (mem_to_reg)
            M2R_ALU:   data = alu_res;
            M2R_LOAD:  data = load_data;
            M2R_LINK:  data = link_data;
            M2R_IMM:   data = imm_data;
            M2R_ADDIE: begin
                data    = imm_data;
                cond_ok = mem_even_flag;
            end
            // Unassigned codes fall back to the ALU result.
            default:   data = alu_res;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register driving the register-file write port
// Ports: clk/rst_n (async active-low), stall/flush control; mem_* MEM-stage results;
//        id_rs/id_rt bypass lookups; wb_we/wb_addr/wb_data write request;
//        fwd_a_hit/fwd_b_hit/fwd_data bypass; addr_err sticky flag; wr_count retired writes.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic             mem_reg_write,
    input  logic             mem_reg_dst,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       mem_rt,
    input  logic [2:0]       mem_to_reg,
    input  logic             mem_even_flag,
    input  logic [N-1:0]     mem_alu_res,
    input  logic [N-1:0]     mem_load_data,
    input  logic [N-1:0]     mem_link_data,
    input  logic [N-1:0]     mem_imm_data,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    output logic             wb_we,
    output logic [4:0]       wb_addr,
    output logic [N-1:0]     wb_data,
    output logic             fwd_a_hit,
    output logic             fwd_b_hit,
    output logic [N-1:0]     fwd_data,
    output logic             addr_err,
    output logic [CNT_W-1:0] wr_count
);

    logic [N-1:0]     sel_data;
    logic             cond_ok;
    logic [4:0]       dst;
    logic             dst_ok;
    logic             live;
    logic             we_next;

    logic             wb_we_q,    wb_we_d;
    logic [4:0]       wb_addr_q,  wb_addr_d;
    logic [N-1:0]     wb_data_q,  wb_data_d;
    logic             addr_err_q, addr_err_d;
    logic [CNT_W-1:0] wr_count_q, wr_count_d;

    wb_select #(.N(N)) u_wb_select (
        .mem_to_reg    (mem_to_reg),
        .mem_even_flag (mem_even_flag),
        .alu_res       (mem_alu_res),
        .load_data     (mem_load_data),
        .link_data     (mem_link_data),
        .imm_data      (mem_imm_data),
        .data          (sel_data),
        .cond_ok       (cond_ok)
    );

    always_comb begin
        dst     = mem_reg_dst ? mem_rd : mem_rt;
        dst_ok  = ({27'd0, dst} < DEPTH);
        // A write that would happen if the address were legal.
        live    = mem_valid & mem_reg_write & ~flush & cond_ok;
        we_next = live & dst_ok;

        wb_we_d    = wb_we_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        addr_err_d = addr_err_q;
        wr_count_d = wr_count_q;

        // Stall freezes everything, so a held write is never counted twice.
        if (!stall) begin
            wb_we_d   = we_next;
            wb_addr_d = dst;
            wb_data_d = sel_data;
            if (live && !dst_ok) begin
                addr_err_d = 1'b1;
            end
            if (we_next && (wr_count_q != '1)) begin
                wr_count_d = wr_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            addr_err_q <= 1'b0;
            wr_count_q <= '0;
        end else begin
            wb_we_q    <= wb_we_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            addr_err_q <= addr_err_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign wb_we     = wb_we_q;
    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;
    assign addr_err  = addr_err_q;
    assign wr_count  = wr_count_q;

    // Register 0 is deliberately not special-cased in the bypass compare.
    assign fwd_a_hit = wb_we_q & (wb_addr_q == id_rs);
    assign fwd_b_hit = wb_we_q & (wb_addr_q == id_rt);
    assign fwd_data  = wb_data_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

    localparam int N     = 32;
    localparam int DEPTH = 16;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             stall, flush;
    logic             mem_valid, mem_reg_write, mem_reg_dst;
    logic [4:0]       mem_rd, mem_rt;
    logic [2:0]       mem_to_reg;
    logic             mem_even_flag;
    logic [N-1:0]     mem_alu_res, mem_load_data, mem_link_data, mem_imm_data;
    logic [4:0]       id_rs, id_rt;
    logic             wb_we;
    logic [4:0]       wb_addr;
    logic [N-1:0]     wb_data;
    logic             fwd_a_hit, fwd_b_hit;
    logic [N-1:0]     fwd_data;
    logic             addr_err;
    logic [CNT_W-1:0] wr_count;

    int n_checks = 0;
    int n_errors = 0;

    mem_wb_stage #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .mem_valid     (mem_valid),
        .mem_reg_write (mem_reg_write),
        .mem_reg_dst   (mem_reg_dst),
        .mem_rd        (mem_rd),
        .mem_rt        (mem_rt),
        .mem_to_reg    (mem_to_reg),
        .mem_even_flag (mem_even_flag),
        .mem_alu_res   (mem_alu_res),
        .mem_load_data (mem_load_data),
        .mem_link_data (mem_link_data),
        .mem_imm_data  (mem_imm_data),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .wb_we         (wb_we),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .fwd_a_hit     (fwd_a_hit),
        .fwd_b_hit     (fwd_b_hit),
        .fwd_data      (fwd_data),
        .addr_err      (addr_err),
        .wr_count      (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wb(input string tag, input logic we, input logic [4:0] addr,
                            input logic [N-1:0] data, input logic [CNT_W-1:0] cnt);
        check({tag, ".we"},   wb_we,    we);
        check({tag, ".addr"}, wb_addr,  addr);
        check({tag, ".data"}, wb_data,  data);
        check({tag, ".cnt"},  wr_count, cnt);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        mem_valid = 1'b0; mem_reg_write = 1'b0; mem_reg_dst = 1'b0;
        mem_rd = '0; mem_rt = '0; mem_to_reg = 3'b000; mem_even_flag = 1'b0;
        mem_alu_res = '0; mem_load_data = '0; mem_link_data = '0; mem_imm_data = '0;
        id_rs = '0; id_rt = '0;

        #1;
        check_wb("reset", 1'b0, 5'd0, 32'h0, 4'd0);
        check("reset.err", addr_err, 1'b0);
        check("reset.fwd_a", fwd_a_hit, 1'b0);
        #11 rst_n = 1'b1;

        // ALU write to rd=5
        mem_valid = 1'b1; mem_reg_write = 1'b1; mem_reg_dst = 1'b1; mem_rd = 5'd5;
        mem_to_reg = 3'b000; mem_alu_res = 32'h1234;
        mem_load_data = 32'hAAAA; mem_link_data = 32'hBBBB; mem_imm_data = 32'hCCCC;
        tick();
        check_wb("alu", 1'b1, 5'd5, 32'h1234, 4'd1);

        // Select codes with reg_write=0: data still captured, nothing retired
        mem_reg_write = 1'b0;
        mem_to_reg = 3'b001; tick(); check_wb("sel001", 1'b0, 5'd5, 32'hAAAA, 4'd1);
        mem_to_reg = 3'b010; tick(); check_wb("sel010", 1'b0, 5'd5, 32'hBBBB, 4'd1);
        mem_to_reg = 3'b011; tick(); check_wb("sel011", 1'b0, 5'd5, 32'hCCCC, 4'd1);
        mem_to_reg = 3'b101; tick(); check_wb("sel101", 1'b0, 5'd5, 32'h1234, 4'd1);
        mem_to_reg = 3'b111; tick(); check_wb("sel111", 1'b0, 5'd5, 32'h1234, 4'd1);

        // addie to rt=3
        mem_reg_write = 1'b1; mem_reg_dst = 1'b0; mem_rt = 5'd3;
        mem_to_reg = 3'b100; mem_imm_data = 32'h7; mem_even_flag = 1'b1;
        tick(); check_wb("addie_even", 1'b1, 5'd3, 32'h7, 4'd2);
        mem_even_flag = 1'b0;
        tick();
        check("addie_odd.we", wb_we, 1'b0);
        check("addie_odd.cnt", wr_count, 4'd2);

        // Capture, then stall three cycles with new inputs (flush on the last)
        mem_reg_dst = 1'b1; mem_rd = 5'd5; mem_to_reg = 3'b000; mem_alu_res = 32'h1111;
        tick(); check_wb("pre_stall", 1'b1, 5'd5, 32'h1111, 4'd3);
        stall = 1'b1; mem_rd = 5'd6; mem_alu_res = 32'h2222;
        tick(); check_wb("stall1", 1'b1, 5'd5, 32'h1111, 4'd3);
        tick(); check_wb("stall2", 1'b1, 5'd5, 32'h1111, 4'd3);
        flush = 1'b1;
        tick(); check_wb("stall_flush", 1'b1, 5'd5, 32'h1111, 4'd3);
        stall = 1'b0;
        tick(); check_wb("flush", 1'b0, 5'd6, 32'h2222, 4'd3);
        flush = 1'b0;

        // Address boundary: 15 legal, 16 and 20 illegal, flag sticks
        mem_rd = 5'd15; mem_alu_res = 32'h0F;
        tick(); check_wb("rd15", 1'b1, 5'd15, 32'h0F, 4'd4);
        check("rd15.err", addr_err, 1'b0);
        mem_rd = 5'd16;
        tick(); check("rd16.we", wb_we, 1'b0); check("rd16.err", addr_err, 1'b1);
        check("rd16.cnt", wr_count, 4'd4);
        mem_rd = 5'd20; mem_alu_res = 32'h3333;
        tick(); check("rd20.we", wb_we, 1'b0); check("rd20.err", addr_err, 1'b1);
        mem_rd = 5'd9; mem_alu_res = 32'hBEEF;
        tick(); check_wb("rd9", 1'b1, 5'd9, 32'hBEEF, 4'd5);
        check("rd9.err_sticky", addr_err, 1'b1);

        // Bypass from registered write
        id_rs = 5'd9; id_rt = 5'd2; #1;
        check("byp.a", fwd_a_hit, 1'b1);
        check("byp.b", fwd_b_hit, 1'b0);
        check("byp.data", fwd_data, 32'hBEEF);
        id_rs = 5'd4; id_rt = 5'd9; #1;
        check("byp2.a", fwd_a_hit, 1'b0);
        check("byp2.b", fwd_b_hit, 1'b1);
        mem_valid = 1'b0; id_rs = 5'd9;
        tick();
        check("byp_nowe.addr", wb_addr, 5'd9);
        check("byp_nowe.a", fwd_a_hit, 1'b0);

        // Register 0 bypasses like any other
        mem_valid = 1'b1; mem_rd = 5'd0; mem_alu_res = 32'h55;
        id_rs = 5'd0; id_rt = 5'd0;
        tick();
        check("r0.a", fwd_a_hit, 1'b1);
        check("r0.b", fwd_b_hit, 1'b1);
        check("r0.cnt", wr_count, 4'd6);

        // Saturation: 20 more writes from count 6
        mem_rd = 5'd1;
        for (int i = 0; i < 20; i++) begin
            mem_alu_res = 32'h100 + i;
            tick();
            if (i == 7) check("sat.cnt14", wr_count, 4'd14);
        end
        check("sat.cnt15", wr_count, 4'd15);

        // Asynchronous reset mid-stream
        #3 rst_n = 1'b0;
        #1;
        check_wb("async_rst", 1'b0, 5'd0, 32'h0, 4'd0);
        check("async_rst.err", addr_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_alu_res = 32'h77;
        tick();
        check_wb("post_rst", 1'b1, 5'd1, 32'h77, 4'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
